// File: rtl/seq_multiplier_pkg.sv
// mult_defs: state encodings and counter-width helper shared by the multiplier and future divider.
package mult_defs;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/mult_sign_adj.sv
// mult_sign_adj: conditional two's-complement negate of a W-bit value.
module mult_sign_adj #(parameter int W = 8) (
    input  logic         i_neg,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    assign o_q = i_neg ? -i_d : i_d;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add WIDTHxWIDTH multiplier with signed mode and start/busy/ready handshake.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import mult_defs::*;
#(parameter int WIDTH = 8) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);
    localparam int CW = cnt_w(WIDTH);

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next, w_res;
    logic               w_final;

    mult_sign_adj #(.W(WIDTH)) u_a_mag (.i_neg(signed_mode & a[WIDTH-1]), .i_d(a), .o_q(w_a_mag));
    mult_sign_adj #(.W(WIDTH)) u_b_mag (.i_neg(signed_mode & b[WIDTH-1]), .i_d(b), .o_q(w_b_mag));
    mult_sign_adj #(.W(2*WIDTH)) u_res (.i_neg(r_neg), .i_d(w_acc_next), .o_q(w_res));

    assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
`ifdef MULT_EARLY_TERM_EN
    // With no multiplier bits left the accumulator is already final.
    assign w_final = (r_cnt == CW'(WIDTH-1)) || (r_mplier == '0);
`else
    assign w_final = r_cnt == CW'(WIDTH-1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            result   <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
        end else if (r_state == RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_final) begin
                result  <= w_res;
                ready   <= 1'b1;
                busy    <= 1'b0;
                r_state <= DONE;
            end
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            ready    <= 1'b0;
            r_state  <= RUN;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for 8- and 16-bit multiplier instances.
module tb_seq_multiplier;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        start = 1'b0, sm = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [15:0] result;
    logic        ready, busy;
    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] result16;
    logic        ready16, busy16;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(sm),
        .a(a), .b(b), .result(result), .ready(ready), .busy(busy));
    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .result(result16), .ready(ready16), .busy(busy16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;
    typedef struct {logic [31:0] res; int lat; int t0;} exp_t;
    exp_t q8[$], q16[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int w, input logic [15:0] bm);
`ifdef MULT_EARLY_TERM_EN
        int h = -1;
        for (int i = 0; i < w; i++) if (bm[i]) h = i;
        return (h + 2 < w) ? h + 2 : w;
`else
        return w;
`endif
    endfunction

    logic rdy8_q = 1'b0, rdy16_q = 1'b0;
    always @(negedge clk) begin : mon8
        exp_t e;
        if (ready && !rdy8_q) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready8: got result %h expected no output", result);
            end else begin
                e = q8.pop_front();
                chk("result8", {16'b0, result}, e.res);
                chk("latency8", cyc - e.t0, e.lat);
            end
        end
        rdy8_q = ready;
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (ready16 && !rdy16_q) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready16: got result %h expected no output", result16);
            end else begin
                e = q16.pop_front();
                chk("result16", result16, e.res);
                chk("latency16", cyc - e.t0, e.lat);
            end
        end
        rdy16_q = ready16;
    end

    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] exp);
        logic [7:0] bm;
        bm = (s && y[7]) ? -y : y;
        @(negedge clk);
        a = x; b = y; sm = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q8.push_back('{{16'b0, exp}, exp_lat(8, {8'b0, bm}), cyc});
    endtask

    task automatic wait8();
        int i;
        for (i = 0; i < 40 && !ready; i++) @(negedge clk);
        if (!ready) begin
            checks++; errors++;
            $display("FAIL timeout8: got ready=0 expected ready=1 within 40 cycles");
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] exp);
        issue8(x, y, s, exp);
        wait8();
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] bm;
        logic [31:0] exp;
        int i;
        bm  = (s && y[15]) ? -y : y;
        exp = s ? 32'(int'($signed(x)) * int'($signed(y))) : {16'b0, x} * {16'b0, y};
        @(negedge clk);
        a16 = x; b16 = y; sm16 = s; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        q16.push_back('{exp, exp_lat(16, bm), cyc});
        for (i = 0; i < 60 && !ready16; i++) @(negedge clk);
        if (!ready16) begin
            checks++; errors++;
            $display("FAIL timeout16: got ready=0 expected ready=1 within 60 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("reset_result", {16'b0, result}, 32'h0);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;

        // 20*10 with busy tracked across the whole operation
        issue8(8'd20, 8'd10, 1'b0, 16'd200);
        lat = exp_lat(8, 16'd10);
        for (int k = 0; k < lat; k++) begin
            chk("busy_running", {31'b0, busy}, 32'h1);
            @(negedge clk);
        end
        chk("busy_done", {31'b0, busy}, 32'h0);

        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001);
        op8(8'h80, 8'h80, 1'b1, 16'h4000);
        op8(8'hFF, 8'h7F, 1'b1, 16'hFF81);
        op8(8'h00, 8'hFB, 1'b1, 16'h0000);
        op8(8'h80, 8'h7F, 1'b1, 16'hC080);
        op8(8'hFF, 8'h00, 1'b0, 16'h0000);
        op8(8'd67, 8'd1, 1'b0, 16'd67);

        // start while busy is ignored; start in DONE restarts with the old result held
        issue8(8'd9, 8'd9, 1'b0, 16'd81);
        @(negedge clk);
        @(negedge clk);
        a = 8'd3; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait8();
        @(negedge clk);
        a = 8'd5; b = 8'd7; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q8.push_back('{32'd35, exp_lat(8, 16'd7), cyc});
        chk("done_restart_ready", {31'b0, ready}, 32'h0);
        chk("done_restart_hold", {16'b0, result}, 32'd81);
        wait8();

        // asynchronous abort mid-operation
        @(negedge clk);
        a = 8'd37; b = 8'd96; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_result", {16'b0, result}, 32'h0);
        chk("abort_ready", {31'b0, ready}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        op8(8'd1, 8'd67, 1'b0, 16'd67);

        op16(16'd1000, 16'd1000, 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        op16(16'h8000, 16'hFFFF, 1'b1);
        op16(16'h8000, 16'h8000, 1'b1);
        op16(16'd67, 16'd1, 1'b0);
        op16(16'h1234, 16'h0000, 1'b1);
        for (int k = 0; k < 8; k++)
            op16(16'($urandom), 16'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 32'h0);
        chk("q16_drained", q16.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
